// File: rtl/dac_sample_buffer.sv
// Buffers CHANNELS FWFT FIFO words per sample and presents them atomically to the DAC driver.
// Optional saturating underrun counter: define DAC_SAMPLE_BUFFER_UNDERRUN_COUNT_EN.
`timescale 1ns/1ps
module dac_sample_buffer #(
  parameter int CHANNELS         = 4,
  parameter int WIDTH            = 32,
  parameter int ZERO_ON_UNDERRUN = 0
) (
  input  logic                      capture_clk,
  input  logic                      reset,
  input  logic                      dac_fifo_open,
  input  logic [WIDTH-1:0]          dac_fifo_data,
  input  logic                      dac_empty,
  output logic                      dac_rden,
  input  logic                      dac_request,
  output logic [CHANNELS*WIDTH-1:0] dac_buffer,
  output logic                      dac_open,
  output logic                      dac_busy,
  output logic                      dac_underrun,
  output logic                      request_error,
  output logic [15:0]               underrun_count,
  output logic [1:0]                fsm_state
);

  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [IW-1:0] LAST = IW'(CHANNELS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EMPTY = 2'd1,
    S_READ  = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t                             state;
  logic   [IW-1:0]                    index;
  logic   [IW-1:0]                    slot;
  logic                               was_underrun;
  // Element CHANNELS-1 sits in the MSBs, so channel k is stored at slot CHANNELS-1-k.
  logic   [CHANNELS-1:0][WIDTH-1:0]   new_data;

  assign fsm_state = state;

  always_comb begin
    slot = LAST - index;
  end

  // Request handshake: dac_request is a one-cycle pulse accepted only while dac_open
  // and !dac_busy (WAIT); the sample appears on dac_buffer, with dac_underrun, one cycle later.
  always_ff @(posedge capture_clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      index         <= '0;
      was_underrun  <= 1'b0;
      new_data      <= '0;
      dac_buffer    <= '0;
      dac_rden      <= 1'b0;
      dac_open      <= 1'b0;
      dac_busy      <= 1'b0;
      dac_underrun  <= 1'b0;
      request_error <= 1'b0;
    end else begin
      dac_underrun  <= 1'b0;
      request_error <= 1'b0;
      if (!dac_fifo_open) begin
        // Close wins over everything; the buffer keeps its last sample.
        state        <= S_IDLE;
        index        <= '0;
        was_underrun <= 1'b0;
        dac_rden     <= 1'b0;
        dac_open     <= 1'b0;
        dac_busy     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: state <= S_EMPTY;
          S_EMPTY: begin
            if (!dac_empty) begin
              state    <= S_READ;
              dac_rden <= 1'b1;
              dac_busy <= 1'b1;
            end
          end
          S_READ: begin
            new_data[slot] <= dac_fifo_data;
            was_underrun   <= was_underrun | dac_empty;
            request_error  <= dac_request;
            if (index == LAST) begin
              state    <= S_WAIT;
              index    <= '0;
              dac_rden <= 1'b0;
              dac_busy <= 1'b0;
              dac_open <= 1'b1;
            end else begin
              index <= index + 1'b1;
            end
          end
          S_WAIT: begin
            dac_open <= 1'b1;
            if (dac_request) begin
              if (!was_underrun) begin
                dac_buffer <= new_data;
              end else if (ZERO_ON_UNDERRUN != 0) begin
                dac_buffer <= '0;
              end
              dac_underrun <= was_underrun;
              was_underrun <= 1'b0;
              index        <= '0;
              state        <= S_READ;
              dac_rden     <= 1'b1;
              dac_busy     <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef DAC_SAMPLE_BUFFER_UNDERRUN_COUNT_EN
  logic [15:0] underrun_cnt;

  // Counts in step with the dac_underrun pulse; restarts on every new open.
  always_ff @(posedge capture_clk or posedge reset) begin
    if (reset) begin
      underrun_cnt <= '0;
    end else if (dac_fifo_open && state == S_IDLE) begin
      underrun_cnt <= '0;
    end else if (dac_fifo_open && state == S_WAIT && dac_request && was_underrun
                 && underrun_cnt != 16'hFFFF) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end

  assign underrun_count = underrun_cnt;
`else
  assign underrun_count = 16'h0000;
`endif

endmodule
